audio_dac_tx: RTL
=================

// Module: audio_dac_tx
// PURPOSE
//   SPI-style serial transmitter feeding a Pmod DA2-class 12-bit DAC (DAC121S101 framing).
//   Output counterpart of the microphone sampling path (MISO/sclk/clk_samp); turns audio samples into serial DAC frames.
//   Accepts one sample per valid/ready handshake and shifts out a 16-bit frame, MSB first.
//   Generates its own sclk and active-low sync from basys_clock.
// PARAMETERS
//   CLK_DIV      4   basys_clock cycles per sclk half-period (>=2); sclk = f_clk/(2*CLK_DIV)
//   IDLE_CYCLES  8   basys_clock cycles sync stays high between frames (>=1)
// PORTS
//   basys_clock   in   1   system clock; the only clock
//   reset         in   1   asynchronous, active-high reset
//   sample        in   12  unsigned DAC code, captured on accept
//   pd_mode       in   2   DAC power-down bits, captured with sample (00 = normal)
//   sample_valid  in   1   sample/pd_mode are presented
//   sample_ready  out  1   high only in IDLE; accept = valid & ready on a rising edge
//   dac_sync      out  1   active-low frame enable (chip select)
//   dac_sclk      out  1   serial clock; idles high
//   dac_mosi      out  1   serial data; changes after rising sclk edges, DAC samples on falling edges
//   busy          out  1   high in SHIFT and GAP
//   frame_done    out  1   one-cycle pulse when a frame's sync deasserts
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, sample_ready=1, dac_sync=1, dac_sclk=1, dac_mosi=0,
//     busy=0, frame_done=0, div_cnt=0, bit_cnt=0, shift register cleared.
//   Frame word = {2'b00, pd_mode, sample}, 16 bits, transmitted bit 15 first.
//   Divider: div_cnt counts 0..CLK_DIV-1 in SHIFT only; tick when div_cnt==CLK_DIV-1; wraps to 0.
//   FSM:
//   IDLE : sample_ready=1. On accept, latch frame word; next cycle SHIFT with dac_sync=0,
//          dac_sclk=1, dac_mosi=word[15], div_cnt=0, bit_cnt=0.
//   SHIFT: each tick toggles dac_sclk.
//          Falling tick (1->0): bit_cnt++.
//          Rising tick (0->1): if bit_cnt==16 -> GAP (dac_sync=1, dac_sclk=1, dac_mosi=0,
//          frame_done=1 for that cycle); else dac_mosi=next bit.
//   GAP  : dac_sync high for IDLE_CYCLES cycles, then IDLE.
//   Timing: dac_sync low exactly 32*CLK_DIV cycles; 16 falling sclk edges per frame;
//     accept-to-sync-low latency 1 cycle; min accept-to-accept = 1+32*CLK_DIV+IDLE_CYCLES cycles.
//   Boundaries:
//     - sample/pd_mode changes while busy are ignored; sample_valid held high gives back-to-back
//       frames at the minimum spacing above.
//     - sample_valid is ignored unless sample_ready=1.
//     - reset mid-frame aborts the frame: outputs take reset values at once, no frame_done.
//     - bit_cnt width is 5 bits; it never exceeds 16.
//     - codes 12'h000 and 12'hFFF need no special handling.
// STRUCTURE
//   Package audio_pkg: DAC_DATA_W=12, DAC_FRAME_W=16, PD_NORMAL=2'b00, PD_HIZ=2'b11,
//     state encoding (IDLE/SHIFT/GAP).
//   Sub-module dac_sclk_gen: div_cnt and tick generation, enabled only in SHIFT.
//     Kept separate so it can be reused by the mic sampler.
//   Top level: FSM, shift register, bit_cnt, gap counter.
// TESTING (CLK_DIV=4, IDLE_CYCLES=8)
//   1. Assert reset mid-run -> same cycle: sample_ready=1, dac_sync=1, dac_sclk=1, dac_mosi=0, busy=0.
//   2. Accept sample=12'hA5C, pd_mode=00 -> bits captured on 16 falling edges = 16'h0A5C;
//      dac_sync low for 128 cycles; exactly one frame_done pulse.
//   3. sample_valid held high with 12'h123 then 12'h456 -> two frames, 16'h0123 then 16'h0456;
//      second sync-low starts 9 cycles after first sync-high; sample_ready=0 throughout each frame.
//   4. Change sample to 12'hFFF during frame carrying 12'h000 -> transmitted word stays 16'h0000.
//   5. Assert reset after 7th falling edge -> dac_sync=1 immediately and no frame_done;
//      next accept of 12'h800 sends 16'h0800 intact.
//   6. Send sample=12'hFFF with pd_mode=2'b11 -> word 16'h3FFF; check sclk period = 8 cycles.

Source files
------------

// File: rtl/audio_dac_tx_pkg.sv
//------------------------------------------------------------------------------
// Module  : audio_pkg
// Brief   : Shared widths, DAC power-down codes and FSM encoding for the DAC path
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

  localparam int DAC_DATA_W  = 12;
  localparam int DAC_FRAME_W = 16;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

  // DAC121S101 framing: two don't-care zeros, power-down bits, then the code.
  function automatic logic [DAC_FRAME_W-1:0] frame_word(input logic [1:0]            pd,
                                                        input logic [DAC_DATA_W-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_dac_tx_if.sv
//------------------------------------------------------------------------------
// Module  : audio_dac_tx_if
// Brief   : Sample valid/ready handshake between an audio source and the DAC transmitter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface audio_dac_tx_if;
  import audio_pkg::*;

  logic [DAC_DATA_W-1:0] sample;
  logic [1:0]            pd_mode;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample,
    output pd_mode,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  pd_mode,
    input  sample_valid,
    output sample_ready
  );

endinterface

`default_nettype wire

// File: rtl/audio_dac_tx_sclk_gen.sv
//------------------------------------------------------------------------------
// Module  : dac_sclk_gen
// Brief   : Half-period divider for a serial clock; ticks once every CLK_DIV cycles
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  output logic      o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_last;

  assign w_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign o_tick = i_en & w_last;

  // Held at zero while disabled so every frame starts with a full half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_dac_tx.sv
//------------------------------------------------------------------------------
// Module  : audio_dac_tx
// Brief   : Serial frame transmitter for a DAC121S101-style 12-bit DAC
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  wire logic       basys_clock,
  input  wire logic       reset,
  audio_dac_tx_if.slave   s_if,
  output logic            dac_sync,
  output logic            dac_sclk,
  output logic            dac_mosi,
  output logic            busy,
  output logic            frame_done
);

  localparam int GAP_W = $clog2(IDLE_CYCLES + 1);

  dac_state_t             r_state;
  logic                   r_ready;
  logic                   r_sync;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   r_busy;
  logic                   r_done;
  logic [4:0]             r_bit_cnt;
  logic [DAC_FRAME_W-2:0] r_shift;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [DAC_FRAME_W-1:0] w_word;
  logic                   w_tick;

  assign w_word = frame_word(s_if.pd_mode, s_if.sample);

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (basys_clock),
    .rst    (reset),
    .i_en   (r_state == ST_SHIFT),
    .o_tick (w_tick)
  );

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_sync    <= 1'b1;
      r_sclk    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_if.sample_valid && r_ready) begin
            r_state   <= ST_SHIFT;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_sync    <= 1'b0;
            r_sclk    <= 1'b1;
            r_mosi    <= w_word[DAC_FRAME_W-1];
            r_shift   <= w_word[DAC_FRAME_W-2:0];
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else if (r_bit_cnt == 5'(DAC_FRAME_W)) begin
              r_state   <= ST_GAP;
              r_sync    <= 1'b1;
              r_mosi    <= 1'b0;
              r_done    <= 1'b1;
              r_gap_cnt <= '0;
            end else begin
              // Data moves on the rising edge so it is stable for the DAC's falling-edge sample.
              r_mosi  <= r_shift[DAC_FRAME_W-2];
              r_shift <= {r_shift[DAC_FRAME_W-3:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(IDLE_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_sync  <= 1'b1;
          r_sclk  <= 1'b1;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.sample_ready = r_ready;
  assign dac_sync          = r_sync;
  assign dac_sclk          = r_sclk;
  assign dac_mosi          = r_mosi;
  assign busy              = r_busy;
  assign frame_done        = r_done;

endmodule

`default_nettype wire
